// File: rtl/systolic_pkg.sv
// Shared types and elaboration-time helpers for the systolic array controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Skew fill/flush across both array edges, plus multiplier and accumulate stages.
  function automatic int drain_cycles(input int n, input int mul_lat);
    return 2 * (n - 1) + mul_lat + 2;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job handshake and operand-buffer read port between a host and systolic_ctrl.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8
) ();

  localparam int KW = clog2_min1(K);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic [KW-1:0]           k_idx;
  logic [N*DATA_WIDTH-1:0] a_col;
  logic [N*DATA_WIDTH-1:0] b_row;

  modport master (
    output start, a_col, b_row,
    input  busy, done, rd_en, k_idx
  );

  modport slave (
    input  start, a_col, b_row,
    output busy, done, rd_en, k_idx
  );

endinterface

// File: rtl/systolic_ctrl_skew_line.sv
// Fixed-depth delay line for one operand lane; DEPTH 0 degenerates to a wire.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // NOTE: every stage is reset, unlike a RAM, because PEs accumulate whatever
        // leaves this line; stale data would corrupt the first job after reset.
        for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
      end else begin
        // NOTE: non-blocking so each stage takes its neighbour's old value (a true shift).
        stage[0] <= din;
        for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Controller for an N x N output-stationary systolic array: clears the PEs, reads
// K operand slices, skews them onto the array edges, waits for drain, pulses done.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MUL_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_ctrl_if.slave          bus,
  output logic                    pe_rst_n,
  output logic [N*DATA_WIDTH-1:0] a_skew,
  output logic [N*DATA_WIDTH-1:0] b_skew
);

  localparam int KW        = clog2_min1(K);
  localparam int DRAIN_CYC = drain_cycles(N, MUL_LAT);
  localparam int DCW       = clog2_min1(DRAIN_CYC);

  localparam logic [KW-1:0]  K_LAST     = KW'(K - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic                 busy_d, done_d, rd_en_d, pe_clr_d;
  logic                 busy_q, done_q, rd_en_q, pe_rst_n_q;
  logic                 op_valid;
  logic [N*DATA_WIDTH-1:0] a_cap, b_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;

    unique case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        k_d     = '0;
      end
      FEED: begin
        // Leave on K-1 rather than on a wrap, so K = 2^KW needs no extra bit.
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          drain_d = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    rd_en_d  = (state_d == FEED);
    pe_clr_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q        <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      pe_rst_n_q <= 1'b0;
      op_valid   <= 1'b0;
      a_cap      <= '0;
      b_cap      <= '0;
    end else begin
      k_q        <= k_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      pe_rst_n_q <= !pe_clr_d;
      // Buffer data arrives one cycle after the read strobe; anything else is gated to zero.
      op_valid   <= rd_en_q;
      a_cap      <= op_valid ? bus.a_col : '0;
      b_cap      <= op_valid ? bus.b_row : '0;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rd_en = rd_en_q;
  assign bus.k_idx = k_q;
  assign pe_rst_n  = pe_rst_n_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_a_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (a_cap[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout (a_skew[i*DATA_WIDTH +: DATA_WIDTH])
    );
    skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_b_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (b_cap[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout (b_skew[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand buffer and PE array models around the DUT,
// C = A*B reference pushed per accepted job and checked when done pulses.
`timescale 1ns/1ps
module tb_systolic_ctrl;

  localparam int N         = 4;
  localparam int K         = 4;
  localparam int DW        = 8;
  localparam int MUL_LAT   = 1;
  localparam int CW        = 2 * DW;
  localparam int DRAIN_CYC = 2 * (N - 1) + MUL_LAT + 2;
  localparam int JOB_LEN   = 1 + K + DRAIN_CYC;

  logic            clk = 1'b0;
  logic            rst;
  logic            pe_rst_n;
  logic [N*DW-1:0] a_skew, b_skew;

  systolic_ctrl_if #(.N(N), .K(K), .DATA_WIDTH(DW)) bus ();

  systolic_ctrl #(.N(N), .K(K), .DATA_WIDTH(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pe_rst_n (pe_rst_n),
    .a_skew   (a_skew),
    .b_skew   (b_skew)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    num_checks++;
    if (act !== exp_v) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- matrices and reference model ----------------
  logic [DW-1:0] mat_a [N][K];
  logic [DW-1:0] mat_b [K][N];
  logic [DW-1:0] job_a [N][K];
  logic [DW-1:0] job_b [K][N];

  typedef struct packed {
    logic [N*N*CW-1:0] c;
    logic [31:0]       done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;

  function automatic logic [N*N*CW-1:0] ref_product();
    logic [N*N*CW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) s += int'(mat_a[i][k]) * int'(mat_b[k][j]);
        r[(i*N+j)*CW +: CW] = s[CW-1:0];
      end
    return r;
  endfunction

  // Job timeline: t = edges since the edge that accepted start, -1 when idle.
  int t         = -1;
  int cyc       = 0;
  bit seen_edge = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t         = -1;
      seen_edge = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      seen_edge = 1'b1;
      if (t < 0) begin
        if (bus.start) begin
          t     = 0;
          job_a = mat_a;
          job_b = mat_b;
          exp_q.push_back('{c: ref_product(), done_cyc: 32'(cyc + JOB_LEN)});
        end
      end else if (t == JOB_LEN) begin
        t = -1;
      end else begin
        t++;
      end
    end
  end

  // ---------------- operand buffer: data one cycle after rd_en ----------------
  bit pend_v = 1'b0;
  int pend_k = 0;

  always @(negedge clk) begin
    if (pend_v) begin
      for (int i = 0; i < N; i++) begin
        bus.a_col[i*DW +: DW] = mat_a[i][pend_k];
        bus.b_row[i*DW +: DW] = mat_b[pend_k][i];
      end
    end else begin
      bus.a_col = $urandom;
      bus.b_row = $urandom;
    end
    pend_v = bus.rd_en;
    pend_k = int'(bus.k_idx);
  end

  // ---------------- PE array model (output stationary) ----------------
  logic [DW-1:0] a_in [N][N], b_in [N][N], pa [N][N], pb [N][N];
  logic [CW-1:0] prod [N][N], acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_skew[i*DW +: DW];
      b_in[0][i] = b_skew[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = pa[i][j-1];
        b_in[j][i] = pb[j-1][i];
      end
    end
  end

  always @(posedge clk or negedge pe_rst_n) begin
    if (!pe_rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j]   <= '0;
          pb[i][j]   <= '0;
          prod[i][j] <= '0;
          acc[i][j]  <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j]   <= a_in[i][j];
          pb[i][j]   <= b_in[i][j];
          prod[i][j] <= a_in[i][j] * b_in[i][j];
          acc[i][j]  <= acc[i][j] + prod[i][j];
        end
    end
  end

  // ---------------- per-cycle control and skew checker ----------------
  logic [5:0]      ctl_exp, ctl_act;
  logic [N*DW-1:0] a_exp, b_exp;
  bit              rd_exp;
  int              kk;

  always @(negedge clk) begin
    rd_exp  = (t >= 1) && (t <= K);
    ctl_exp = {t >= 0, t == JOB_LEN, rd_exp, rd_exp ? 2'(t - 1) : 2'd0,
               (t == 0) ? 1'b0 : ((t > 0) ? 1'b1 : seen_edge)};
    ctl_act = {bus.busy, bus.done, bus.rd_en, bus.k_idx, pe_rst_n};
    a_exp   = '0;
    b_exp   = '0;
    for (int i = 0; i < N; i++) begin
      kk = t - 3 - i;
      if (t >= 0 && kk >= 0 && kk < K) begin
        a_exp[i*DW +: DW] = job_a[i][kk];
        b_exp[i*DW +: DW] = job_b[kk][i];
      end
    end
    check($sformatf("ctl t=%0d", t), ctl_act, ctl_exp);
    check($sformatf("a_skew t=%0d", t), a_skew, a_exp);
    check($sformatf("b_skew t=%0d", t), b_skew, b_exp);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("done_cycle", cyc, exp_e.done_cyc);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            check($sformatf("c[%0d][%0d]", i, j), acc[i][j], exp_e.c[(i*N+j)*CW +: CW]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset(input string name);
    check({name, "_ctl"}, {bus.busy, bus.done, bus.rd_en, bus.k_idx, pe_rst_n}, 6'b0);
    check({name, "_skew"}, {a_skew, b_skew}, '0);
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        mat_a[i][k] = DW'($urandom);
        mat_b[k][i] = DW'($urandom);
      end
  endtask

  // Called at a negedge while idle; returns at the following negedge.
  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns at the negedge of the first idle cycle after done.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 4 * JOB_LEN && !seen; c++) begin
      @(posedge clk);
      #2;
      seen = bus.done;
    end
    check({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a_col = '0;
    bus.b_row = '0;
    #1;
    check_reset("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Identity times B gives B.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        mat_a[i][k] = (i == k) ? 8'd1 : 8'd0;
        mat_b[k][i] = DW'(4 * k + i + 1);
      end
    start_pulse();
    wait_done("identity");

    // All-ones operands wrap the accumulator.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        mat_a[i][k] = 8'hFF;
        mat_b[k][i] = 8'hFF;
      end
    start_pulse();
    wait_done("all_ff");

    // Marker on the deepest lane for the skew timing.
    rand_mats();
    mat_a[3][0] = 8'h5A;
    start_pulse();
    wait_done("lane_skew");

    // Start held through two jobs; only two done pulses.
    rand_mats();
    bus.start = 1'b1;
    wait_done("held_job1");
    rand_mats();
    wait_done("held_job2");
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of FEED aborts the job.
    rand_mats();
    start_pulse();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset("mid_feed");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rand_mats();
    start_pulse();
    wait_done("after_abort");

    // Random jobs with a spurious start while busy.
    for (int n = 0; n < 6; n++) begin
      rand_mats();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_pulse();
      repeat ($urandom_range(1, 8)) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done($sformatf("rand%0d", n));
    end

    repeat (5) @(negedge clk);
    check("pending_jobs", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter: N, 4, array dimension (N x N PEs, N >= 2).
REQ-002 Parameter: K, 4, inner (shared) matrix dimension, K >= 1.
REQ-003 Parameter: DATA_WIDTH, 8, operand width per lane.
REQ-004 Parameter: MUL_LAT, 1, PE multiplier pipeline latency in cycles.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  input  1  clock; all state updates on rising edge.
REQ-007 Port: rst  input  1  asynchronous active-low reset.
REQ-008 Port: start  input  1  job request; sampled only in IDLE.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle pulse, results stable in array.
REQ-011 Port: pe_rst_n  output  1  registered clear to array PE rst; low clears accumulators.
REQ-012 Port: rd_en  output  1  operand buffer read strobe.
REQ-013 Port: k_idx  output  clog2(K) (min 1)  column-of-A / row-of-B read address.
REQ-014 Port: a_col  input  N*DATA_WIDTH  A[i][k_idx] per lane i, valid 1 cycle after rd_en.
REQ-015 Port: b_row  input  N*DATA_WIDTH  B[k_idx][j] per lane j, valid 1 cycle after rd_en.
REQ-016 Port: a_skew  output  N*DATA_WIDTH  skewed row operands to array left edge.
REQ-017 Port: b_skew  output  N*DATA_WIDTH  skewed column operands to array top edge.

Function
REQ-018 FSM states IDLE, CLEAR, FEED, DRAIN, DONE; all outputs registered.
REQ-019 IDLE -> CLEAR when start=1; start in any other state is ignored, no queuing.
REQ-020 CLEAR: exactly 1 cycle, pe_rst_n=0; otherwise pe_rst_n=1 outside reset.
REQ-021 FEED: exactly K cycles, rd_en=1, k_idx = 0..K-1 incrementing by 1; k_idx=0 when not FEED.
REQ-022 Operand valid = rd_en delayed 1 cycle; inputs captured as zero when valid=0.
REQ-023 Lane i of a_skew (and lane j of b_skew) delayed i (j) cycles after capture; lane 0 zero added delay beyond capture.
REQ-024 Skew registers shift every cycle; zeros fill behind data so PEs accumulate 0 outside the job window.
REQ-025 DRAIN: exactly DRAIN_CYC = 2*(N-1) + MUL_LAT + 2 cycles, counter-driven, no early exit.
REQ-026 DONE: 1 cycle, done=1, then IDLE; start may be accepted in the IDLE cycle immediately following.
REQ-027 done asserts exactly 1+K+DRAIN_CYC cycles after the edge sampling start (N=4,K=4,MUL_LAT=1: 14).
REQ-028 Counters saturate-free: FEED counter wraps only via state exit at K-1; no overflow at K = 2^w.
REQ-029 Accumulation width 2*DATA_WIDTH, modulo 2^(2*DATA_WIDTH); controller adds no overflow detection.

Reset
REQ-030 rst=0 immediately: state IDLE, busy=0, done=0, rd_en=0, k_idx=0, pe_rst_n=0, all skew registers 0.
REQ-031 pe_rst_n released (1) on first clock edge after rst deasserts.
REQ-032 Reset mid-job aborts; no done pulse; next job requires new start.

Structure
REQ-033 Package systolic_pkg: state encoding, DRAIN_CYC function, clog2 helper.
REQ-034 Sub-module skew_line (parameter DEPTH, DATA_WIDTH), one instance per lane for A and B; DEPTH=0 is a wire.

Verification
REQ-035 N=4,K=4: start pulse -> busy next cycle, pe_rst_n low 1 cycle, rd_en high 4 cycles k_idx 0,1,2,3, done at cycle 14.
REQ-036 A=identity, B[i][j]=4*i+j+1 with 4x4 PE array -> C equals B after done.
REQ-037 All operands 255, K=4 -> every C = 63492 (260100 mod 65536).
REQ-038 start held high through job -> single job, done once; second job starts the cycle after IDLE re-entry, C from job 2 only.
REQ-039 rst low during FEED -> outputs at reset values immediately, no done; fresh start gives correct C.
REQ-040 Lane skew check: a_col lane 3 = 0x5A at first capture -> appears on a_skew lane 3 exactly 3 cycles after lane 0 data.
